// File: rtl/alu32_slice_add_sequencer.sv
// -----------------------------------------------------------------------------
// alu32_slice_add_sequencer
// Performs a WORD_W-bit add/subtract by running one external SLICE_W-bit adder
// slice over NSLICE consecutive cycles, LSB slice first, with the inter-slice
// carry held in a register. The result is offered on a valid/ready output.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   request handshake (op_a, op_b, op_sub)
//   out_valid / out_ready result handshake (result, cout, overflow)
//   slc_a, slc_b, slc_cin operands driven to the external slice (0 outside RUN)
//   slc_sum, slc_cout     combinational sum/carry returned by the slice
// -----------------------------------------------------------------------------
module alu32_slice_add_sequencer #(
    parameter int unsigned SLICE_W = 8,
    parameter int unsigned WORD_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  op_a,
    input  logic [WORD_W-1:0]  op_b,
    input  logic               op_sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD_W-1:0]  result,
    output logic               cout,
    output logic               overflow,
    output logic [SLICE_W-1:0] slc_a,
    output logic [SLICE_W-1:0] slc_b,
    output logic               slc_cin,
    input  logic [SLICE_W-1:0] slc_sum,
    input  logic               slc_cout
);

    localparam int unsigned NSLICE = WORD_W / SLICE_W;
    localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [WORD_W-1:0]   a_q, a_d;
    logic [WORD_W-1:0]   b_q, b_d;
    logic                sub_q, sub_d;
    logic                carry_q, carry_d;
    logic [WORD_W-1:0]   result_q, result_d;
    logic                cout_q, cout_d;
    logic                ovf_q, ovf_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state, slice drive and result assembly
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        slc_a    = '0;
        slc_b    = '0;
        slc_cin  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    // Subtract is A + ~B + 1; the +1 enters as slice-0 carry-in.
                    b_d     = op_sub ? ~op_b : op_b;
                    sub_d   = op_sub;
                    k_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                slc_a   = a_q[k_q*SLICE_W +: SLICE_W];
                slc_b   = b_q[k_q*SLICE_W +: SLICE_W];
                slc_cin = (k_q == '0) ? sub_q : carry_q;
                result_d[k_q*SLICE_W +: SLICE_W] = slc_sum;
                carry_d = slc_cout;
                if (k_q == K_LAST) begin
                    cout_d  = slc_cout;
                    // Operand signs equal but result sign differs.
                    ovf_d   = (a_q[WORD_W-1] == b_q[WORD_W-1]) &&
                              (slc_sum[SLICE_W-1] != a_q[WORD_W-1]);
                    k_d     = '0;
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu32_slice_add_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for alu32_slice_add_sequencer: a behavioural 8-bit adder slice closes
// the loop; table vectors plus backpressure and mid-RUN reset sequences.
// -----------------------------------------------------------------------------
module tb_alu32_slice_add_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        cout;
    logic        overflow;
    logic [7:0]  slc_a;
    logic [7:0]  slc_b;
    logic        slc_cin;
    logic [7:0]  slc_sum;
    logic        slc_cout;
    logic [8:0]  sum9;

    int n_vec;
    int n_err;

    alu32_slice_add_sequencer #(.SLICE_W(8), .WORD_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow),
        .slc_a     (slc_a),
        .slc_b     (slc_b),
        .slc_cin   (slc_cin),
        .slc_sum   (slc_sum),
        .slc_cout  (slc_cout)
    );

    // External adder slice model
    always_comb begin
        sum9 = {1'b0, slc_a} + {1'b0, slc_b} + {8'd0, slc_cin};
    end
    assign slc_sum  = sum9[7:0];
    assign slc_cout = sum9[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vt[9];

    logic [7:0] rec_a[4];
    logic [7:0] rec_b[4];
    logic       rec_cin[4];
    int         lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request and wait (bounded) for out_valid, recording slice drive.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub);
        @(negedge clk);
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        op_sub   = sub;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
            if (lat < 4) begin
                rec_a[lat]   = slc_a;
                rec_b[lat]   = slc_b;
                rec_cin[lat] = slc_cin;
            end
            lat++;
        end
        if (!out_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: out_valid not seen after %0d cycles, expected 4", lat);
        end
    endtask

    // Independent slice-drive expectation built from the operands.
    task automatic chk_slices(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [31:0] bi;
        logic [8:0]  s;
        logic        c;
        bi = sub ? ~b : b;
        c  = sub;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("slc_a[%0d]", k), 32'(rec_a[k]), 32'(a[k*8 +: 8]));
            chk($sformatf("slc_b[%0d]", k), 32'(rec_b[k]), 32'(bi[k*8 +: 8]));
            chk($sformatf("slc_cin[%0d]", k), 32'(rec_cin[k]), 32'(c));
            s = {1'b0, a[k*8 +: 8]} + {1'b0, bi[k*8 +: 8]} + {8'd0, c};
            c = s[8];
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_sub    = 1'b0;
        out_ready = 1'b1;

        vt[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vt[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vt[2] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vt[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vt[4] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vt[5] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0};
        vt[6] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vt[7] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vt[8] = '{32'h0000000A, 32'h00000003, 1'b1, 32'h00000007, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result",    result,         32'd0);
        chk("rst_cout",      32'(cout),      32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        chk("rst_slc_a",     32'(slc_a),     32'd0);
        chk("rst_slc_cin",   32'(slc_cin),   32'd0);
        rst = 1'b0;

        // Table-driven operations
        for (int v = 0; v < 9; v++) begin
            issue(vt[v].a, vt[v].b, vt[v].sub);
            chk($sformatf("v%0d_latency", v),  32'(lat),      32'd4);
            chk($sformatf("v%0d_result", v),   result,        vt[v].res);
            chk($sformatf("v%0d_cout", v),     32'(cout),     32'(vt[v].co));
            chk($sformatf("v%0d_overflow", v), 32'(overflow), 32'(vt[v].ov));
            chk_slices(vt[v].a, vt[v].b, vt[v].sub);
            if (v == 1) begin
                for (int k = 1; k < 4; k++)
                    chk($sformatf("wrap_cin_%0d", k), 32'(rec_cin[k]), 32'd1);
            end
            if (v == 2) begin
                chk("sub_cin0", 32'(rec_cin[0]), 32'd1);
                chk("sub_b0",   32'(rec_b[0]),   32'h000000F8);
            end
            @(negedge clk);
            chk($sformatf("v%0d_post_in_ready", v),  32'(in_ready),  32'd1);
            chk($sformatf("v%0d_post_out_valid", v), 32'(out_valid), 32'd0);
            chk($sformatf("v%0d_post_result", v),    result,         vt[v].res);
        end

        // Backpressure with ignored requests
        out_ready = 1'b0;
        issue(32'h7FFFFFFF, 32'h00000001, 1'b0);
        in_valid = 1'b1;
        op_a     = 32'h11111111;
        op_b     = 32'h22222222;
        op_sub   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready",  32'(in_ready),  32'd0);
            chk("bp_result",    result,         32'h80000000);
            chk("bp_cout",      32'(cout),      32'd0);
            chk("bp_overflow",  32'(overflow),  32'd1);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("bp_rel_in_ready",  32'(in_ready),  32'd1);
        chk("bp_rel_out_valid", 32'(out_valid), 32'd0);
        chk("bp_rel_result",    result,         32'h80000000);

        // Reset in the middle of RUN (slice 2)
        @(negedge clk);
        in_valid = 1'b1;
        op_a     = 32'hA5A5A5A5;
        op_b     = 32'h0F0F0F0F;
        op_sub   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mid_slc_a_k2", 32'(slc_a), 32'h000000A5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_in_ready",  32'(in_ready),  32'd1);
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_result",    result,         32'd0);
        chk("mr_slc_cin",   32'(slc_cin),   32'd0);
        repeat (4) begin
            @(negedge clk);
            chk("mr_no_valid", 32'(out_valid), 32'd0);
        end
        issue(32'h00010000, 32'h0000FFFF, 1'b0);
        chk("mr_new_latency", 32'(lat),      32'd4);
        chk("mr_new_result",  result,        32'h0001FFFF);
        chk("mr_new_cout",    32'(cout),     32'd0);
        chk("mr_new_ovf",     32'(overflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
